modexp_arbiter: RTL and testbench

Shares one `RL_binary` modular-exponentiation engine between up to `NREQ` requesters, such as the sender- and receiver-side RSA steps of the oblivious-transfer flow. Requests are granted round-robin. The block latches the winner's operands and sequences the engine's start/end handshake. It returns the result to the winner with a one-cycle `done` pulse. Requesters therefore no longer need private engine instances.

---
 rtl/modexp_pkg.sv | 39 +++
 rtl/RL_binary.sv | 62 ++++++
 rtl/modexp_arbiter.sv | 116 +++++++++++
 tb/tb_modexp_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared definitions for modular-exponentiation arbiters.
//   state_e  : arbiter FSM encoding (IDLE=0, START=1, WAIT=2, DONE=3)
//   DefaultW : default operand/result width, matching RL_binary
//   rr_pick  : round-robin priority pick over up to MaxReq requesters
package modexp_pkg;

  localparam int unsigned DefaultW = 32;
  localparam int unsigned MaxReq   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req searching upward from ptr, wrapping at nreq (2..MaxReq).
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                       input logic [2:0]        ptr,
                                       input int unsigned       nreq);
    rr_pick_t    pick;
    logic [31:0] j;
    pick = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      j = (32'(ptr) + i) % nreq;
      if (i < nreq && !pick.found && req[j[2:0]]) begin
        pick.found = 1'b1;
        pick.idx   = j[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/RL_binary.sv
// Right-to-left binary modular exponentiation engine: r = base^exp mod modulus.
//   clk, rstn (sync, active-low)
//   md_start : one-cycle start; operands sampled on this edge (modulus must be >= 2)
//   md_end   : one-cycle pulse when r is valid
//   r        : result, held until the next start
module RL_binary #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         md_start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic         md_end,
  output logic [W-1:0] r
);

  logic         run_q;
  logic [W-1:0] b_q, e_q, m_q, r_q;

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q  <= 1'b0;
      b_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      md_end <= 1'b0;
    end else begin
      md_end <= 1'b0;
      if (md_start) begin
        b_q   <= base % modulus;
        e_q   <= exp;
        m_q   <= modulus;
        r_q   <= W'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        if (e_q == '0) begin
          run_q  <= 1'b0;
          md_end <= 1'b1;
        end else begin
          if (e_q[0]) r_q <= mulmod(r_q, b_q, m_q);
          b_q <= mulmod(b_q, b_q, m_q);
          e_q <= e_q >> 1;
        end
      end
    end
  end

  assign r = r_q;

endmodule

// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one RL_binary engine among NREQ requesters.
//   clk, rst (sync, active-high)
//   req                          : per-requester request level
//   base_flat/exp_flat/mod_flat  : operands, requester i at [i*W +: W]
//   done                         : one-hot one-cycle completion pulse
//   result                       : base^exp mod modulus while done != 0, else 0
//   busy                         : high outside IDLE
//   gnt_id                       : current or last granted requester
module modexp_arbiter
  import modexp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = DefaultW,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] base_flat,
  input  logic [NREQ*W-1:0] exp_flat,
  input  logic [NREQ*W-1:0] mod_flat,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic [IDW-1:0]    gnt_id
);

  state_e            state_q;
  logic [IDW-1:0]    ptr_q, gnt_id_q;
  logic [W-1:0]      base_q, exp_q, mod_q, res_q;
  logic              md_start, md_end;
  logic [W-1:0]      md_r;
  logic [MaxReq-1:0] req_pad;
  rr_pick_t          pick;
  logic [IDW-1:0]    win_idx;
  logic [W-1:0]      win_mod;

  always_comb begin
    req_pad           = '0;
    req_pad[NREQ-1:0] = req;
    pick              = rr_pick(req_pad, 3'(ptr_q), NREQ);
    win_idx           = IDW'(pick.idx);
    win_mod           = mod_flat[win_idx*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      md_start <= 1'b0;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      res_q    <= '0;
    end else begin
      md_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick.found) begin
            gnt_id_q <= win_idx;
            base_q   <= base_flat[win_idx*W +: W];
            exp_q    <= exp_flat[win_idx*W +: W];
            mod_q    <= win_mod;
            // Anything mod 0 or 1 is reported as 0 without touching the engine.
            if (win_mod <= W'(1)) begin
              res_q   <= '0;
              state_q <= StDone;
            end else begin
              md_start <= 1'b1;
              state_q  <= StStart;
            end
          end
        end
        StStart: state_q <= StWait;
        StWait: begin
          if (md_end) begin
            res_q   <= md_r;
            state_q <= StDone;
          end
        end
        StDone: begin
          ptr_q   <= (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  RL_binary #(
    .W(W)
  ) u_engine (
    .clk      (clk),
    .rstn     (~rst),
    .md_start (md_start),
    .base     (base_q),
    .exp      (exp_q),
    .modulus  (mod_q),
    .md_end   (md_end),
    .r        (md_r)
  );

  always_comb begin
    done   = '0;
    result = '0;
    if (state_q == StDone) begin
      done[gnt_id_q] = 1'b1;
      result         = res_q;
    end
  end

  assign busy   = (state_q != StIdle);
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
module tb_modexp_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [W-1:0]      op_b [NREQ];
  logic [W-1:0]      op_e [NREQ];
  logic [W-1:0]      op_m [NREQ];
  logic [NREQ*W-1:0] base_flat, exp_flat, mod_flat;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              busy;
  logic [IDW-1:0]    gnt_id;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign base_flat[g*W +: W] = op_b[g];
    assign exp_flat[g*W +: W]  = op_e[g];
    assign mod_flat[g*W +: W]  = op_m[g];
  end

  always #5 clk = ~clk;

  modexp_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .base_flat (base_flat),
    .exp_flat  (exp_flat),
    .mod_flat  (mod_flat),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .gnt_id    (gnt_id)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [W-1:0] powmod(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    longint unsigned r, x, mm, ee;
    if (m <= 1) return '0;
    mm = 64'(m);
    ee = 64'(e);
    x  = 64'(b) % mm;
    r  = 1;
    while (ee != 0) begin
      if (ee[0]) r = (r * x) % mm;
      x  = (x * x) % mm;
      ee = ee >> 1;
    end
    return r[W-1:0];
  endfunction

  // Reference model state
  bit              m_pend = 1'b0;
  bit              m_short;
  int              m_win = 0, m_cnt = 0, m_ptr = 0;
  logic [W-1:0]    m_res;
  logic [NREQ-1:0] granted   = '0;
  logic [NREQ-1:0] done_seen = '0;
  int              log_idx[$];
  logic [W-1:0]    log_res[$];
  logic [NREQ-1:0] log_done[$];
  bit              saw_start = 1'b0;

  always @(negedge clk) begin
    bit was_idle;
    if (dut.md_start) saw_start = 1'b1;
    if (rst) begin
      m_pend  = 1'b0;
      m_ptr   = 0;
      granted = '0;
    end else begin
      was_idle = !m_pend;
      if (was_idle) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_result", result, 0);
      end else begin
        m_cnt++;
        chk("busy", busy, 1);
        chk("gnt_id", gnt_id, m_win);
        if (done != '0) begin
          chk("done_onehot", done, 1 << m_win);
          chk("result", result, m_res);
          if (m_short) chk("short_latency", m_cnt, 1);
          else chk("long_latency_min3", m_cnt >= 3, 1);
          log_idx.push_back(m_win);
          log_res.push_back(result);
          log_done.push_back(done);
          done_seen      = done_seen | done;
          granted[m_win] = 1'b0;
          m_ptr          = (m_win + 1) % NREQ;
          m_pend         = 1'b0;
        end else begin
          chk("result_zero", result, 0);
          if ((m_short && m_cnt >= 1) || m_cnt > 200) begin
            chk("done_missing", done, 1 << m_win);
            granted[m_win] = 1'b0;
            m_ptr          = (m_win + 1) % NREQ;
            m_pend         = 1'b0;
          end
        end
      end
      if (was_idle && req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (!m_pend && req[idx]) begin
            m_win        = idx;
            m_res        = powmod(op_b[idx], op_e[idx], op_m[idx]);
            m_short      = (op_m[idx] <= 1);
            m_cnt        = 0;
            m_pend       = 1'b1;
            granted[idx] = 1'b1;
          end
        end
      end
    end
  end

  // One clock step; requesters drop req after their done.
  task automatic cyc(output logic [NREQ-1:0] fin);
    @(posedge clk);
    #1;
    fin = done_seen;
    for (int i = 0; i < NREQ; i++)
      if (done_seen[i]) req[i] = 1'b0;
    done_seen = '0;
  endtask

  task automatic wait_logs(input int n);
    logic [NREQ-1:0] f;
    for (int c = 0; c < 400; c++) begin
      cyc(f);
      if (log_idx.size() >= n) break;
    end
    if (log_idx.size() < n) chk("wait_done_count", log_idx.size(), n);
  endtask

  task automatic clear_logs();
    log_idx.delete();
    log_res.delete();
    log_done.delete();
  endtask

  task automatic set_op(input int i, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m);
    op_b[i] = b;
    op_e[i] = e;
    op_m[i] = m;
  endtask

  task automatic do_reset();
    logic [NREQ-1:0] f;
    cyc(f);
    rst = 1'b1;
    req = '0;
    cyc(f);
    cyc(f);
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] active = '0;

  task automatic rand_step(input bit allow_new);
    logic [NREQ-1:0] f;
    cyc(f);
    active = active & ~f;
    for (int i = 0; i < NREQ; i++) begin
      if (!active[i]) begin
        if (allow_new && $urandom_range(0, 3) == 0) begin
          op_b[i] = $urandom;
          op_e[i] = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 20));
          case ($urandom_range(0, 5))
            0:       op_m[i] = '0;
            1:       op_m[i] = W'(1);
            2:       op_m[i] = W'(2);
            default: op_m[i] = $urandom;
          endcase
          req[i]    = 1'b1;
          active[i] = 1'b1;
        end else begin
          op_b[i] = $urandom;
          op_m[i] = $urandom;
        end
      end else if (granted[i]) begin
        if ($urandom_range(0, 7) == 0) op_b[i] = $urandom;
        if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [NREQ-1:0] f;
    int n0;
    for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, '0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_md_start", dut.md_start, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_res_reg", dut.res_q, 0);
    cyc(f);
    rst = 1'b0;

    // Single request
    clear_logs();
    cyc(f);
    set_op(1, 3, 5, 7);
    req = 4'b0010;
    wait_logs(1);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    repeat (3) cyc(f);
    chk("t1_once", log_idx.size(), 1);
    if (log_idx.size() >= 1) begin
      chk("t1_done", log_done[0], 4'b0010);
      chk("t1_result", log_res[0], 5);
    end

    // Simultaneous requests after reset
    do_reset();
    clear_logs();
    set_op(0, 2, 10, 1000);
    set_op(1, 4, 13, 497);
    set_op(3, 7, 0, 11);
    req = 4'b1011;
    wait_logs(3);
    if (log_idx.size() >= 3) begin
      chk("t2_order0", log_idx[0], 0);
      chk("t2_order1", log_idx[1], 1);
      chk("t2_order2", log_idx[2], 3);
      chk("t2_res0", log_res[0], 24);
      chk("t2_res1", log_res[1], 445);
      chk("t2_res2", log_res[2], 1);
    end

    // Round-robin wrap
    clear_logs();
    cyc(f);
    set_op(3, 5, 3, 13);
    req = 4'b1000;
    wait_logs(1);
    cyc(f);
    set_op(0, 2, 3, 5);
    set_op(3, 3, 3, 5);
    req = 4'b1001;
    wait_logs(3);
    if (log_idx.size() >= 3) begin
      chk("t3_first", log_idx[0], 3);
      chk("t3_wrap", log_idx[1], 0);
      chk("t3_last", log_idx[2], 3);
      chk("t3_res0", log_res[0], 8);
      chk("t3_res1", log_res[1], 3);
      chk("t3_res2", log_res[2], 2);
    end

    // Modulus boundary
    clear_logs();
    cyc(f);
    saw_start = 1'b0;
    set_op(2, 9, 3, 1);
    req = 4'b0100;
    wait_logs(1);
    chk("t4_no_md_start", saw_start, 0);
    if (log_idx.size() >= 1) begin
      chk("t4_idx", log_idx[0], 2);
      chk("t4_result", log_res[0], 0);
    end

    // Reset in WAIT
    clear_logs();
    cyc(f);
    set_op(0, 3, 32'hFFFF_FFFF, 7);
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      cyc(f);
      if (dut.state_q == 2'd2) break;
    end
    chk("t5_in_wait", dut.state_q, 2);
    rst = 1'b1;
    req = '0;
    n0  = log_idx.size();
    @(negedge clk);
    chk("t5_done_in_rst", done, 0);
    cyc(f);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_state", dut.state_q, 0);
    chk("t5_ptr", dut.ptr_q, 0);
    chk("t5_done", done, 0);
    repeat (5) cyc(f);
    chk("t5_no_done", log_idx.size(), n0);
    set_op(0, 3, 5, 7);
    req = 4'b0001;
    wait_logs(n0 + 1);
    if (log_idx.size() >= n0 + 1) begin
      chk("t5_rereq_idx", log_idx[n0], 0);
      chk("t5_rereq_res", log_res[n0], 5);
    end

    // Operand change after grant
    clear_logs();
    cyc(f);
    set_op(2, 6, 7, 11);
    req = 4'b0100;
    cyc(f);
    set_op(2, 100, 1, 13);
    wait_logs(1);
    if (log_idx.size() >= 1) chk("t6_latched", log_res[0], 8);

    // Randomized traffic, then drain
    active = '0;
    for (int c = 0; c < 4000; c++) rand_step(1'b1);
    for (int c = 0; c < 3000; c++) begin
      if (active == '0 && !m_pend) break;
      rand_step(1'b0);
    end
    chk("drain_active", active, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
